puf_ro_array_ctrl: RTL and testbench

PUF_RO_ARRAY_CTRL -- requirements
Module: puf_ro_array_ctrl

---
 rtl/puf_ro_array_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_puf_ro_array_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_ro_array_ctrl.sv
// Ring-oscillator PUF controller: enables two selected ROs, counts their synchronised
// rising edges over a fixed window and reports which one ran faster.
module puf_ro_array_ctrl #(
    parameter int N_RO          = 8,
    parameter int CNT_BIT_SIZE  = 16,
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 4,
    localparam int SEL_W        = (N_RO > 1) ? $clog2(N_RO) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_start,
    input  logic [SEL_W-1:0]        i_chal_a,
    input  logic [SEL_W-1:0]        i_chal_b,
    input  logic [N_RO-1:0]         i_ro,
    output logic [N_RO-1:0]         o_ro_en,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic                    o_resp,
    output logic                    o_tie,
    output logic                    o_sat,
    output logic                    o_err,
    output logic [CNT_BIT_SIZE-1:0] o_cnt_a,
    output logic [CNT_BIT_SIZE-1:0] o_cnt_b,
    output logic [2:0]              o_state
);

    // Handshake: i_start is a request with no ready; it is sampled only while o_busy=0
    // (IDLE) and i_en=1. Each accepted request yields exactly one o_valid strobe unless
    // aborted; each rejected request yields exactly one o_err strobe.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        COUNT   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int WC_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int WC_W   = $clog2(WC_MAX + 1);

    localparam logic [WC_W-1:0]         SETTLE_LAST = WC_W'(SETTLE_CYCLES - 1);
    localparam logic [WC_W-1:0]         WIN_LAST    = WC_W'(WIN_CYCLES - 1);
    localparam logic [CNT_BIT_SIZE-1:0] CNT_MAX     = '1;
    localparam logic [CNT_BIT_SIZE-1:0] CNT_PRE     = CNT_MAX - 1'b1;
    localparam logic [N_RO-1:0]         ONE_HOT0    = N_RO'(1);

    state_t                  state_q;
    state_t                  state_d;
    logic                    accept;
    logic                    reject;
    logic                    chal_ok;

    logic [SEL_W-1:0]        chal_a_q;
    logic [SEL_W-1:0]        chal_b_q;
    logic [WC_W-1:0]         win_q;

    logic [N_RO-1:0]         sync1_q;
    logic [N_RO-1:0]         sync2_q;
    logic [N_RO-1:0]         hist_q;
    logic [N_RO-1:0]         rise;
    logic                    edge_a;
    logic                    edge_b;

    logic [CNT_BIT_SIZE-1:0] cnt_a_q;
    logic [CNT_BIT_SIZE-1:0] cnt_b_q;
    logic                    sat_q;
    logic [N_RO-1:0]         sel_mask;

    assign chal_ok = (i_chal_a != i_chal_b)
                  && (int'(i_chal_a) < N_RO)
                  && (int'(i_chal_b) < N_RO);

    assign sel_mask = (ONE_HOT0 << i_chal_a) | (ONE_HOT0 << i_chal_b);

    assign rise   = sync2_q & ~hist_q;
    assign edge_a = rise[chal_a_q];
    assign edge_b = rise[chal_b_q];

    assign o_busy  = (state_q != IDLE);
    assign o_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping i_en anywhere past IDLE aborts straight back to IDLE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_en && i_start) begin
                    if (chal_ok) begin
                        accept  = 1'b1;
                        state_d = ARM;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            ARM: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (win_q == SETTLE_LAST) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (win_q == WIN_LAST) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                state_d = i_en ? DONE : IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One cycle counter shared by ARM and COUNT; it restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (state_d != state_q) begin
            win_q <= '0;
        end else if (state_q == ARM || state_q == COUNT) begin
            win_q <= win_q + 1'b1;
        end else begin
            win_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= i_ro;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chal_a_q <= '0;
            chal_b_q <= '0;
        end else if (accept) begin
            chal_a_q <= i_chal_a;
            chal_b_q <= i_chal_b;
        end
    end

    // Counters stick at all-ones; reaching all-ones marks the result as saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            sat_q   <= 1'b0;
        end else if (accept) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            sat_q   <= 1'b0;
        end else if (state_q == COUNT) begin
            if (edge_a && (cnt_a_q != CNT_MAX)) begin
                cnt_a_q <= cnt_a_q + 1'b1;
                if (cnt_a_q == CNT_PRE) begin
                    sat_q <= 1'b1;
                end
            end
            if (edge_b && (cnt_b_q != CNT_MAX)) begin
                cnt_b_q <= cnt_b_q + 1'b1;
                if (cnt_b_q == CNT_PRE) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ro_en <= '0;
        end else if (accept) begin
            o_ro_en <= sel_mask;
        end else if (!(state_d == ARM || state_d == COUNT)) begin
            o_ro_en <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_err   <= reject;
            o_valid <= (state_q == DONE) && i_en;
        end
    end

    // Results only change in COMPARE, so aborts and rejects leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_resp  <= 1'b0;
            o_tie   <= 1'b0;
            o_sat   <= 1'b0;
            o_cnt_a <= '0;
            o_cnt_b <= '0;
        end else if (state_q == COMPARE && i_en) begin
            o_resp  <= (cnt_a_q > cnt_b_q);
            o_tie   <= (cnt_a_q == cnt_b_q);
            o_sat   <= sat_q;
            o_cnt_a <= cnt_a_q;
            o_cnt_b <= cnt_b_q;
        end
    end

endmodule

// File: tb/tb_puf_ro_array_ctrl.sv
// Directed bench for puf_ro_array_ctrl: table of measurements plus hand-written
// reject, abort and reset sequences on two differently-parameterised instances.
module tb_puf_ro_array_ctrl;

    typedef struct {
        int sel;
        int a;
        int b;
        int per_a;
        int per_b;
        int ca;
        int cb;
        int resp;
        int tie;
        int sat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [1:0] chal_a1 = '0;
    logic [1:0] chal_b1 = '0;
    logic [2:0] chal_a2 = '0;
    logic [2:0] chal_b2 = '0;
    logic [3:0] ro1 = '0;
    logic [4:0] ro2 = '0;

    logic [3:0] ro_en1;
    logic [4:0] ro_en2;
    logic       busy1, valid1, resp1, tie1, sat1, err1;
    logic       busy2, valid2, resp2, tie2, sat2, err2;
    logic [3:0] cnt_a1, cnt_b1;
    logic [1:0] cnt_a2, cnt_b2;
    logic [2:0] state1, state2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int per1[4];
    int per2[5];
    vec_t vecs[8];
    int last_ca[2];
    int last_cb[2];
    int last_resp[2];

    int s_ro_en, s_busy, s_valid, s_resp, s_tie, s_sat, s_err, s_ca, s_cb, s_state;

    puf_ro_array_ctrl #(
        .N_RO(4), .CNT_BIT_SIZE(4), .WIN_CYCLES(16), .SETTLE_CYCLES(3)
    ) dut1 (
        .clk(clk), .rst(rst), .i_en(en), .i_start(start1),
        .i_chal_a(chal_a1), .i_chal_b(chal_b1), .i_ro(ro1),
        .o_ro_en(ro_en1), .o_busy(busy1), .o_valid(valid1), .o_resp(resp1),
        .o_tie(tie1), .o_sat(sat1), .o_err(err1),
        .o_cnt_a(cnt_a1), .o_cnt_b(cnt_b1), .o_state(state1)
    );

    puf_ro_array_ctrl #(
        .N_RO(5), .CNT_BIT_SIZE(2), .WIN_CYCLES(16), .SETTLE_CYCLES(3)
    ) dut2 (
        .clk(clk), .rst(rst), .i_en(en), .i_start(start2),
        .i_chal_a(chal_a2), .i_chal_b(chal_b2), .i_ro(ro2),
        .o_ro_en(ro_en2), .o_busy(busy2), .o_valid(valid2), .o_resp(resp2),
        .o_tie(tie2), .o_sat(sat2), .o_err(err2),
        .o_cnt_a(cnt_a2), .o_cnt_b(cnt_b2), .o_state(state2)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Free-running square-wave ROs, one clk-period resolution, 50% duty.
    always @(negedge clk) begin
        cyc++;
        for (int ch = 0; ch < 4; ch++)
            ro1[ch] = (per1[ch] == 0) ? 1'b0 : ((cyc % per1[ch]) < (per1[ch] / 2));
        for (int ch = 0; ch < 5; ch++)
            ro2[ch] = (per2[ch] == 0) ? 1'b0 : ((cyc % per2[ch]) < (per2[ch] / 2));
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            s_ro_en = int'(ro_en1); s_busy = int'(busy1); s_valid = int'(valid1);
            s_resp = int'(resp1); s_tie = int'(tie1); s_sat = int'(sat1);
            s_err = int'(err1); s_ca = int'(cnt_a1); s_cb = int'(cnt_b1);
            s_state = int'(state1);
        end else begin
            s_ro_en = int'(ro_en2); s_busy = int'(busy2); s_valid = int'(valid2);
            s_resp = int'(resp2); s_tie = int'(tie2); s_sat = int'(sat2);
            s_err = int'(err2); s_ca = int'(cnt_a2); s_cb = int'(cnt_b2);
            s_state = int'(state2);
        end
    endtask

    task automatic check_all_zero(input int sel);
        sample(sel);
        check($sformatf("rst d%0d ro_en", sel), s_ro_en, 0);
        check($sformatf("rst d%0d busy", sel), s_busy, 0);
        check($sformatf("rst d%0d valid", sel), s_valid, 0);
        check($sformatf("rst d%0d resp", sel), s_resp, 0);
        check($sformatf("rst d%0d tie", sel), s_tie, 0);
        check($sformatf("rst d%0d sat", sel), s_sat, 0);
        check($sformatf("rst d%0d err", sel), s_err, 0);
        check($sformatf("rst d%0d cnt_a", sel), s_ca, 0);
        check($sformatf("rst d%0d cnt_b", sel), s_cb, 0);
        check($sformatf("rst d%0d state", sel), s_state, 0);
    endtask

    task automatic set_periods(input int i);
        for (int ch = 0; ch < 4; ch++) per1[ch] = 0;
        for (int ch = 0; ch < 5; ch++) per2[ch] = 0;
        if (vecs[i].sel == 0) begin
            per1[vecs[i].a] = vecs[i].per_a;
            per1[vecs[i].b] = vecs[i].per_b;
        end else begin
            per2[vecs[i].a] = vecs[i].per_a;
            per2[vecs[i].b] = vecs[i].per_b;
        end
    endtask

    // Driver: present a challenge for one edge; returns at the negedge after acceptance.
    task automatic drive_start(input int sel, input int a, input int b);
        if (sel == 0) begin
            chal_a1 = 2'(a); chal_b1 = 2'(b); start1 = 1'b1;
        end else begin
            chal_a2 = 3'(a); chal_b2 = 3'(b); start2 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Sample n is taken n cycles after the accepting edge k: ARM n=0..2, COUNT n=3..18,
    // COMPARE n=19, DONE n=20, o_valid at n=21 (edge k+21).
    task automatic run_vec(input int i, input int pre);
        vec_t v;
        int mask;
        v = vecs[i];
        set_periods(i);
        repeat (pre) @(negedge clk);
        drive_start(v.sel, v.a, v.b);
        mask = (1 << v.a) | (1 << v.b);
        for (int n = 0; n <= 22; n++) begin
            sample(v.sel);
            check($sformatf("v%0d valid n%0d", i, n), s_valid, (n == 21) ? 1 : 0);
            if (n == 0 || n == 10) check($sformatf("v%0d ro_en n%0d", i, n), s_ro_en, mask);
            if (n == 19) check($sformatf("v%0d ro_en compare", i), s_ro_en, 0);
            if (n == 0 || n == 20) check($sformatf("v%0d busy n%0d", i, n), s_busy, 1);
            if (n == 21) begin
                check($sformatf("v%0d busy after", i), s_busy, 0);
                check($sformatf("v%0d cnt_a", i), s_ca, v.ca);
                check($sformatf("v%0d cnt_b", i), s_cb, v.cb);
                check($sformatf("v%0d resp", i), s_resp, v.resp);
                check($sformatf("v%0d tie", i), s_tie, v.tie);
                check($sformatf("v%0d sat", i), s_sat, v.sat);
            end
            if (n < 22) @(negedge clk);
        end
        last_ca[v.sel] = v.ca;
        last_cb[v.sel] = v.cb;
        last_resp[v.sel] = v.resp;
    endtask

    task automatic reject_chk(input int sel, input int a, input int b, input logic en_val,
                              input int exp_err);
        en = en_val;
        drive_start(sel, a, b);
        sample(sel);
        check($sformatf("rej d%0d %0d,%0d err", sel, a, b), s_err, exp_err);
        check($sformatf("rej d%0d %0d,%0d busy", sel, a, b), s_busy, 0);
        check($sformatf("rej d%0d %0d,%0d cnt_a", sel, a, b), s_ca, last_ca[sel]);
        check($sformatf("rej d%0d %0d,%0d cnt_b", sel, a, b), s_cb, last_cb[sel]);
        check($sformatf("rej d%0d %0d,%0d resp", sel, a, b), s_resp, last_resp[sel]);
        @(negedge clk);
        sample(sel);
        check($sformatf("rej d%0d %0d,%0d err drop", sel, a, b), s_err, 0);
        en = 1'b1;
    endtask

    initial begin
        int any_valid;
        int any_busy;
        int any_err;

        // Edge counts are exact: a waveform with period p dividing 16, sampled once per
        // clk over 16 consecutive cycles, shows exactly 16/p rising edges.
        vecs[0] = '{sel: 0, a: 1, b: 2, per_a: 4,  per_b: 8, ca: 4, cb: 2, resp: 1, tie: 0, sat: 0};
        vecs[1] = '{sel: 0, a: 3, b: 0, per_a: 4,  per_b: 4, ca: 4, cb: 4, resp: 0, tie: 1, sat: 0};
        vecs[2] = '{sel: 0, a: 0, b: 3, per_a: 8,  per_b: 2, ca: 2, cb: 8, resp: 0, tie: 0, sat: 0};
        vecs[3] = '{sel: 0, a: 2, b: 1, per_a: 16, per_b: 0, ca: 1, cb: 0, resp: 1, tie: 0, sat: 0};
        vecs[4] = '{sel: 0, a: 3, b: 2, per_a: 2,  per_b: 4, ca: 8, cb: 4, resp: 1, tie: 0, sat: 0};
        vecs[5] = '{sel: 1, a: 0, b: 1, per_a: 2,  per_b: 0, ca: 3, cb: 0, resp: 1, tie: 0, sat: 1};
        vecs[6] = '{sel: 1, a: 0, b: 1, per_a: 8,  per_b: 0, ca: 2, cb: 0, resp: 1, tie: 0, sat: 0};
        vecs[7] = '{sel: 1, a: 4, b: 2, per_a: 4,  per_b: 8, ca: 3, cb: 2, resp: 1, tie: 0, sat: 1};
        last_ca = '{0, 0};
        last_cb = '{0, 0};
        last_resp = '{0, 0};

        // Reset state, then first challenge on the first edge after release.
        repeat (3) @(negedge clk);
        check_all_zero(0);
        check_all_zero(1);
        en = 1'b1;
        rst = 1'b0;
        run_vec(0, 0);

        for (int i = 1; i < 8; i++) run_vec(i, 4);

        // Rejected challenges: equal indices, out-of-range index on the 5-channel instance.
        reject_chk(0, 2, 2, 1'b1, 1);
        reject_chk(1, 2, 2, 1'b1, 1);
        reject_chk(1, 0, 5, 1'b1, 1);
        reject_chk(1, 7, 1, 1'b1, 1);
        // Disabled in IDLE: neither a bad nor a good challenge does anything.
        reject_chk(1, 0, 5, 1'b0, 0);
        reject_chk(0, 1, 2, 1'b0, 0);

        // Abort by i_en=0 at COUNT cycle 5 (n=7).
        set_periods(0);
        repeat (4) @(negedge clk);
        drive_start(0, 1, 2);
        repeat (7) @(negedge clk);
        sample(0);
        check("abort pre state", s_state, 2);
        en = 1'b0;
        @(negedge clk);
        sample(0);
        check("abort state", s_state, 0);
        check("abort busy", s_busy, 0);
        check("abort ro_en", s_ro_en, 0);
        check("abort cnt_a", s_ca, last_ca[0]);
        check("abort cnt_b", s_cb, last_cb[0]);
        check("abort resp", s_resp, last_resp[0]);
        any_valid = 0;
        any_busy = 0;
        any_err = 0;
        for (int n = 0; n < 25; n++) begin
            if (n == 2) begin
                chal_a1 = 2'd1; chal_b1 = 2'd2; start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            @(negedge clk);
            sample(0);
            any_valid |= s_valid;
            any_busy |= s_busy;
            any_err |= s_err;
        end
        check("abort no valid", any_valid, 0);
        check("disabled no busy", any_busy, 0);
        check("disabled no err", any_err, 0);
        en = 1'b1;
        run_vec(1, 1);

        // Reset mid-COUNT: everything clears at once, then a full measurement follows.
        set_periods(2);
        repeat (4) @(negedge clk);
        drive_start(0, 0, 3);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero(0);
        check_all_zero(1);
        last_ca = '{0, 0};
        last_cb = '{0, 0};
        last_resp = '{0, 0};
        @(negedge clk);
        rst = 1'b0;
        run_vec(2, 1);
        run_vec(5, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
